// File: rtl/button_debounce_sync.sv
// Debounce conditioner for a raw board input: two-flop synchroniser, a
// counter-qualified four-state FSM, one-cycle edge pulses and a saturating
// count of aborted qualifications for bring-up.
module button_debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       raw_in,
  output logic       value,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] bounce_count
);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] CHECK_HIGH  = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] CHECK_LOW   = 2'd3;

  // Terminal count of the qualification window; the counter only ever
  // compares equal against this, so it never needs to wrap.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 value_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 bounce_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchroniser; only sync2 is visible to the FSM.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Next-state, counter and output decisions from the synchronised level.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    value_nxt  = value;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    bounce_inc = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync2) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync2) begin
          state_nxt  = STABLE_LOW;
          cnt_nxt    = '0;
          bounce_inc = 1'b1;
        end else if (cnt == LAST_CNT) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          value_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync2) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (sync2) begin
          state_nxt  = STABLE_HIGH;
          cnt_nxt    = '0;
          bounce_inc = 1'b1;
        end else if (cnt == LAST_CNT) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          value_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; Reset overrides everything,
  // including a qualification that would complete on the same edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= STABLE_LOW;
      cnt          <= '0;
      value        <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      busy         <= 1'b0;
      bounce_count <= 8'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      value        <= value_nxt;
      rise_pulse   <= rise_nxt;
      fall_pulse   <= fall_nxt;
      busy         <= (state_nxt == CHECK_HIGH) || (state_nxt == CHECK_LOW);
      bounce_count <= bounce_inc ? sat_inc8(bounce_count) : bounce_count;
    end
  end

endmodule

// File: tb/tb_button_debounce_sync.sv
// Bench for button_debounce_sync: cycle-accurate vector table for reset,
// clean press and clean release, then hand-written multi-cycle sequences
// for bounce, reset corners, counter saturation and the 1-cycle variant.
module tb_button_debounce_sync;

  logic       CLK;
  logic       Reset;
  logic       raw_in;
  logic       value;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] bounce_count;

  logic       reset1;
  logic       raw1;
  logic       value1;
  logic       rise1;
  logic       fall1;
  logic       busy1;
  logic [7:0] bc1;

  int errors = 0;
  int checks = 0;

  button_debounce_sync #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
    .CLK(CLK), .Reset(Reset), .raw_in(raw_in), .value(value),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy),
    .bounce_count(bounce_count)
  );

  button_debounce_sync #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .CLK(CLK), .Reset(reset1), .raw_in(raw1), .value(value1),
    .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1),
    .bounce_count(bc1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic rst;
    logic raw;
    logic exp_value;
    logic exp_rise;
    logic exp_fall;
    logic exp_busy;
    int   exp_bc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic rst, input logic raw, input logic v,
                         input logic r, input logic f, input logic b);
    vec_t row;
    row.rst = rst; row.raw = raw; row.exp_value = v;
    row.exp_rise = r; row.exp_fall = f; row.exp_busy = b; row.exp_bc = 0;
    tbl.push_back(row);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_main();
    Reset = 1'b1; raw_in = 1'b0;
    step(); step();
    Reset = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    int first;
    int rises;
    int falls;
    int early;
    int changes;
    logic pat[6];

    Reset = 1'b1; raw_in = 1'b0;
    reset1 = 1'b1; raw1 = 1'b0;

    // Reset then idle low: nothing moves.
    add_row(1, 0, 0, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add_row(0, 0, 0, 0, 0, 0);
    // Clean press: raw high before edge 1, accept on edge 7.
    for (int e = 1; e <= 11; e++)
      add_row(0, 1, (e >= 7), (e == 7), 0, (e >= 3 && e <= 6));
    // Clean release: same timing, falling.
    for (int e = 1; e <= 11; e++)
      add_row(0, 0, (e < 7), 0, (e == 7), (e >= 3 && e <= 6));

    foreach (tbl[i]) begin
      Reset  = tbl[i].rst;
      raw_in = tbl[i].raw;
      step();
      chk($sformatf("row%0d value", i), int'(value), int'(tbl[i].exp_value));
      chk($sformatf("row%0d rise", i), int'(rise_pulse), int'(tbl[i].exp_rise));
      chk($sformatf("row%0d fall", i), int'(fall_pulse), int'(tbl[i].exp_fall));
      chk($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].exp_busy));
      chk($sformatf("row%0d bounce_count", i), int'(bounce_count), tbl[i].exp_bc);
    end

    // Bouncy press 1,0,1,1,0,1 then held high: two aborts, accept at edge 12.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    first = -1; rises = 0; falls = 0;
    for (int e = 1; e <= 20; e++) begin
      raw_in = (e <= 6) ? pat[e-1] : 1'b1;
      step();
      if (rise_pulse) rises++;
      if (fall_pulse) falls++;
      if (value && first < 0) begin
        first = e;
        chk("bouncy rise_at_accept", int'(rise_pulse), 1);
      end
    end
    chk("bouncy accept_edge", first, 12);
    chk("bouncy rise_count", rises, 1);
    chk("bouncy fall_count", falls, 0);
    chk("bouncy bounce_count", int'(bounce_count), 2);

    // Reset while STABLE_HIGH: value drops without a fall pulse.
    Reset = 1'b1;
    step();
    chk("rst_high value", int'(value), 0);
    chk("rst_high fall", int'(fall_pulse), 0);
    chk("rst_high bounce_count", int'(bounce_count), 0);
    reset_main();

    // Reset at edge 5 of a qualifying press; full latency restarts.
    first = -1; early = 0; rises = 0;
    raw_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      Reset = (e == 5);
      step();
      if (e == 5) begin
        chk("rst_mid value", int'(value), 0);
        chk("rst_mid busy", int'(busy), 0);
      end
      if (rise_pulse) rises++;
      if ((rise_pulse || fall_pulse) && e < 12) early++;
      if (value && first < 0) first = e;
    end
    Reset = 1'b0;
    chk("rst_mid early_pulses", early, 0);
    chk("rst_mid accept_edge", first, 12);
    chk("rst_mid rise_count", rises, 1);
    reset_main();

    // Reset on the same edge the qualification would complete.
    first = -1; early = 0;
    raw_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      Reset = (e == 7);
      step();
      if (e == 7) begin
        chk("rst_accept value", int'(value), 0);
        chk("rst_accept rise", int'(rise_pulse), 0);
      end
      if ((rise_pulse || fall_pulse) && e < 14) early++;
      if (value && first < 0) first = e;
    end
    Reset = 1'b0;
    chk("rst_accept early_pulses", early, 0);
    chk("rst_accept accept_edge", first, 14);
    reset_main();

    // 300 short glitches: counter saturates, level never changes.
    changes = 0;
    for (int g = 1; g <= 300; g++) begin
      for (int c = 0; c < 6; c++) begin
        raw_in = (c < 3);
        step();
        if (value || rise_pulse || fall_pulse) changes++;
      end
      if (g == 100) chk("sat bounce_count_100", int'(bounce_count), 100);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (value || rise_pulse || fall_pulse) changes++;
    end
    chk("sat bounce_count", int'(bounce_count), 255);
    chk("sat level_changes", changes, 0);
    chk("sat busy_idle", int'(busy), 0);

    // DEBOUNCE_CYCLES=1: accept one edge after entering CHECK_HIGH.
    reset1 = 1'b1; raw1 = 1'b0;
    step(); step();
    reset1 = 1'b0;
    step(); step(); step();
    first = -1; rises = 0;
    raw1 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 3) chk("d1 busy_edge3", int'(busy1), 1);
      if (e == 4) begin
        chk("d1 busy_edge4", int'(busy1), 0);
        chk("d1 rise_edge4", int'(rise1), 1);
      end
      if (rise1) rises++;
      if (value1 && first < 0) first = e;
    end
    chk("d1 accept_edge", first, 4);
    chk("d1 rise_count", rises, 1);
    chk("d1 bounce_count", int'(bc1), 0);
    chk("d1 fall", int'(fall1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
